// File: rtl/v9958_cpu_bridge.sv
// Z80 I/O bus to V9958 VDP access bridge.
// Synchronises the asynchronous RD/WR I/O strobes into the pixel clock domain,
// decodes the port address, and turns each strobe into exactly one cpu_req
// pulse. Read data is captured RD_LAT cycles after the request and held on the
// pad until the CPU releases RD.
module v9958_cpu_bridge #(
  parameter logic [5:0] BASE_ADDR = 6'b100110,
  parameter int         RD_LAT    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] A,
  input  logic       rd_iorq_n,
  input  logic       wr_iorq_n,
  input  logic [7:0] cd_in,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  output logic       cs_n,
  output logic       cpu_req,
  output logic       cpu_wrt,
  output logic [1:0] cpu_adr,
  output logic [7:0] cpu_dbo,
  input  logic [7:0] cpu_dbi
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4,
    WR_HOLD = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       rd_meta_q, rd_s_q, wr_meta_q, wr_s_q;
  logic [1:0] flush_q;
  logic       armed_q, armed_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] dbo_q, dbo_d;
  logic [7:0] latch_q, latch_d;
  logic       hit;

  assign hit = (A[7:2] == BASE_ADDR);

  // Two-flop synchronisers plus a flush marker: the synchroniser outputs are
  // forced high by reset, so they only reflect the real strobes once the
  // marker has filled. Rearm must not trust those forced values, otherwise a
  // strobe held low across reset would be treated as a fresh access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_meta_q <= 1'b1;
      rd_s_q    <= 1'b1;
      wr_meta_q <= 1'b1;
      wr_s_q    <= 1'b1;
      flush_q   <= 2'b00;
    end else begin
      rd_meta_q <= rd_iorq_n;
      rd_s_q    <= rd_meta_q;
      wr_meta_q <= wr_iorq_n;
      wr_s_q    <= wr_meta_q;
      flush_q   <= {flush_q[0], 1'b1};
    end
  end

  // FSM state and access registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= 3'd0;
      adr_q   <= 2'd0;
      dbo_q   <= 8'd0;
      latch_q <= 8'd0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dbo_q   <= dbo_d;
      latch_q <= latch_d;
    end
  end

  // Next-state logic and request outputs.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dbo_d   = dbo_q;
    latch_d = latch_q;
    cpu_req = 1'b0;
    cpu_wrt = 1'b0;

    // Both strobes seen high (after the synchronisers are trustworthy) arms
    // the bridge for the next access; accepting an access disarms it.
    if (flush_q[1] && rd_s_q && wr_s_q) armed_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (armed_q && hit && !wr_s_q) begin
          adr_d   = A[1:0];
          dbo_d   = cd_in;
          armed_d = 1'b0;
          state_d = WR_REQ;
        end else if (armed_q && hit && !rd_s_q) begin
          adr_d   = A[1:0];
          armed_d = 1'b0;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        cpu_req = 1'b1;
        cpu_wrt = 1'b1;
        state_d = WR_HOLD;
      end
      RD_REQ: begin
        cpu_req = 1'b1;
        cnt_d   = LAT_M1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          latch_d = cpu_dbi;
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_HOLD: if (rd_s_q) state_d = IDLE;
      WR_HOLD: if (wr_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_adr = adr_q;
  assign cpu_dbo = dbo_q;
  assign cd_out  = latch_q;
  // Pad drive follows the raw RD so the bus is released without sync delay.
  assign cd_oe   = (state_q == RD_HOLD) && !rd_iorq_n && hit;
  assign cs_n    = ~(reset_n && hit && (!rd_iorq_n || !wr_iorq_n));

endmodule

// File: tb/tb_v9958_cpu_bridge.sv
// Directed bench for v9958_cpu_bridge with a request scoreboard.
// A second instance with RD_LAT=7 shares all inputs for the short-strobe case.
module tb_v9958_cpu_bridge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] A;
  logic       rd_iorq_n, wr_iorq_n;
  logic [7:0] cd_in, cpu_dbi;
  logic [7:0] cd_out, cpu_dbo;
  logic       cd_oe, cs_n, cpu_req, cpu_wrt;
  logic [1:0] cpu_adr;
  logic [7:0] cd_out7, cpu_dbo7;
  logic       cd_oe7, cs_n7, cpu_req7, cpu_wrt7;
  logic [1:0] cpu_adr7;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       wrt;
    logic [1:0] adr;
    logic [7:0] dbo;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int         req7_cnt = 0;
  logic       wrt7_last = 1'b0;
  logic [1:0] adr7_last = 2'd0;
  logic [7:0] dbo7_last = 8'd0;
  logic       oe7_seen = 1'b0;
  logic       oe_seen = 1'b0;

  v9958_cpu_bridge #(.BASE_ADDR(6'b100110), .RD_LAT(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .A(A), .rd_iorq_n(rd_iorq_n), .wr_iorq_n(wr_iorq_n),
    .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n), .cpu_req(cpu_req),
    .cpu_wrt(cpu_wrt), .cpu_adr(cpu_adr), .cpu_dbo(cpu_dbo), .cpu_dbi(cpu_dbi)
  );

  v9958_cpu_bridge #(.BASE_ADDR(6'b100110), .RD_LAT(7)) u_dut7 (
    .clk(clk), .reset_n(reset_n), .A(A), .rd_iorq_n(rd_iorq_n), .wr_iorq_n(wr_iorq_n),
    .cd_in(cd_in), .cd_out(cd_out7), .cd_oe(cd_oe7), .cs_n(cs_n7), .cpu_req(cpu_req7),
    .cpu_wrt(cpu_wrt7), .cpu_adr(cpu_adr7), .cpu_dbo(cpu_dbo7), .cpu_dbi(cpu_dbi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every request pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (cpu_req) begin
      if (sb.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("req_wrt", {31'd0, cpu_wrt}, {31'd0, e.wrt});
        chk("req_adr", {30'd0, cpu_adr}, {30'd0, e.adr});
        if (e.wrt) chk("req_dbo", {24'd0, cpu_dbo}, {24'd0, e.dbo});
        chk("req_latency", cyc, e.cyc);
      end
    end
    if (cpu_req7) begin
      req7_cnt++;
      wrt7_last = cpu_wrt7;
      adr7_last = cpu_adr7;
      dbo7_last = cpu_dbo7;
    end
    if (cd_oe7) oe7_seen = 1'b1;
    if (cd_oe)  oe_seen  = 1'b1;
  end

  task automatic push(input logic wrt, input logic [1:0] adr, input logic [7:0] dbo);
    exp_t e;
    e.wrt = wrt;
    e.adr = adr;
    e.dbo = dbo;
    e.cyc = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int len);
    A = addr;
    cd_in = data;
    wr_iorq_n = 1'b0;
    push(1'b1, addr[1:0], data);
    tick(2);
    chk("wr_cs_n", {31'd0, cs_n}, 32'd0);
    tick(len - 2);
    wr_iorq_n = 1'b1;
    tick(6);
  endtask

  initial begin
    int n0;
    reset_n = 1'b0;
    A = 8'h98;
    cd_in = 8'h00;
    cpu_dbi = 8'h00;
    rd_iorq_n = 1'b1;
    wr_iorq_n = 1'b1;
    #2;
    chk("rst_req", {31'd0, cpu_req}, 32'd0);
    chk("rst_wrt", {31'd0, cpu_wrt}, 32'd0);
    chk("rst_adr", {30'd0, cpu_adr}, 32'd0);
    chk("rst_dbo", {24'd0, cpu_dbo}, 32'd0);
    chk("rst_cd_out", {24'd0, cd_out}, 32'd0);
    chk("rst_cd_oe", {31'd0, cd_oe}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(4);

    // Write to port 1.
    do_write(8'h99, 8'h5A, 10);
    chk("wr_adr_held", {30'd0, cpu_adr}, 32'd1);
    chk("wr_dbo_held", {24'd0, cpu_dbo}, 32'h5A);

    // Read from port 0: data driven until RD rises, released in the same cycle.
    A = 8'h98;
    cpu_dbi = 8'hC3;
    rd_iorq_n = 1'b0;
    push(1'b0, 2'd0, 8'h00);
    tick(12);
    chk("rd_cd_oe", {31'd0, cd_oe}, 32'd1);
    chk("rd_cd_out", {24'd0, cd_out}, 32'hC3);
    chk("rd_cs_n", {31'd0, cs_n}, 32'd0);
    rd_iorq_n = 1'b1;
    #1;
    chk("rd_release_oe", {31'd0, cd_oe}, 32'd0);
    tick(6);

    // Miss: write then read outside the decoded range.
    A = 8'hA0;
    cd_in = 8'hEE;
    wr_iorq_n = 1'b0;
    tick(4);
    chk("miss_wr_cs_n", {31'd0, cs_n}, 32'd1);
    tick(4);
    wr_iorq_n = 1'b1;
    tick(4);
    oe_seen = 1'b0;
    rd_iorq_n = 1'b0;
    tick(8);
    chk("miss_rd_cs_n", {31'd0, cs_n}, 32'd1);
    rd_iorq_n = 1'b1;
    tick(4);
    chk("miss_cd_oe", {31'd0, oe_seen}, 32'd0);

    // Simultaneous strobes: only the write is issued.
    A = 8'h9B;
    cd_in = 8'h3C;
    rd_iorq_n = 1'b0;
    wr_iorq_n = 1'b0;
    push(1'b1, 2'd3, 8'h3C);
    tick(10);
    rd_iorq_n = 1'b1;
    wr_iorq_n = 1'b1;
    tick(6);

    // Short read on the long-latency instance, then a normal write.
    n0 = req7_cnt;
    oe7_seen = 1'b0;
    oe_seen = 1'b0;
    A = 8'h98;
    cpu_dbi = 8'h77;
    rd_iorq_n = 1'b0;
    push(1'b0, 2'd0, 8'h00);
    tick(5);
    rd_iorq_n = 1'b1;
    tick(15);
    chk("short_req7_cnt", req7_cnt - n0, 32'd1);
    chk("short_req7_wrt", {31'd0, wrt7_last}, 32'd0);
    chk("short_oe7", {31'd0, oe7_seen}, 32'd0);
    chk("short_oe", {31'd0, oe_seen}, 32'd0);
    chk("short_latch7", {24'd0, cd_out7}, 32'h77);
    do_write(8'h9A, 8'h5E, 10);
    chk("short_next_cnt7", req7_cnt - n0, 32'd2);
    chk("short_next_wrt7", {31'd0, wrt7_last}, 32'd1);
    chk("short_next_adr7", {30'd0, adr7_last}, 32'd2);
    chk("short_next_dbo7", {24'd0, dbo7_last}, 32'h5E);
    chk("cs_n_match7", {31'd0, cs_n7}, {31'd0, cs_n});

    // Reset during WR_HOLD with WR still low.
    A = 8'h99;
    cd_in = 8'h11;
    wr_iorq_n = 1'b0;
    push(1'b1, 2'd1, 8'h11);
    tick(6);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, cpu_req}, 32'd0);
    chk("mid_rst_adr", {30'd0, cpu_adr}, 32'd0);
    chk("mid_rst_dbo", {24'd0, cpu_dbo}, 32'd0);
    chk("mid_rst_cd_out", {24'd0, cd_out}, 32'd0);
    chk("mid_rst_cd_oe", {31'd0, cd_oe}, 32'd0);
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    chk("post_rst_cs_n", {31'd0, cs_n}, 32'd0);
    wr_iorq_n = 1'b1;
    tick(5);
    do_write(8'h99, 8'h22, 8);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
